// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: direction key codes, direction enum, FSM states.
package pacman_pkg;

    // Key codes the game logic understands as movement commands.
    localparam logic [7:0] DIR_UP    = 8'h1A;
    localparam logic [7:0] DIR_LEFT  = 8'h04;
    localparam logic [7:0] DIR_DOWN  = 8'h16;
    localparam logic [7:0] DIR_RIGHT = 8'h07;
    localparam logic [7:0] DIR_NONE  = 8'h00;

    // Ordering matters: the random scan walks UP, LEFT, DOWN, RIGHT.
    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirLeft  = 2'd1,
        DirDown  = 2'd2,
        DirRight = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDecide = 2'd1,
        StHold   = 2'd2
    } state_e;

    function automatic dir_e reverse_dir(input dir_e d);
        unique case (d)
            DirUp:    return DirDown;
            DirLeft:  return DirRight;
            DirDown:  return DirUp;
            default:  return DirLeft;
        endcase
    endfunction

    function automatic logic [7:0] dir_code(input dir_e d);
        unique case (d)
            DirUp:    return DIR_UP;
            DirLeft:  return DIR_LEFT;
            DirDown:  return DIR_DOWN;
            default:  return DIR_RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/ghost_dir_gen_if.sv
// Game-side signals of the ghost direction generator.
interface ghost_dir_gen_if;
    logic       pause;
    logic       chase_en;
    logic [4:0] mapL;
    logic [4:0] mapR;
    logic [4:0] mapB;
    logic [4:0] mapT;
    logic [9:0] ghostX;
    logic [9:0] ghostY;
    logic [9:0] targetX;
    logic [9:0] targetY;
    logic [7:0] randomkeycode;

    modport master (
        output pause, chase_en, mapL, mapR, mapB, mapT, ghostX, ghostY, targetX, targetY,
        input  randomkeycode
    );

    modport slave (
        input  pause, chase_en, mapL, mapR, mapB, mapT, ghostX, ghostY, targetX, targetY,
        output randomkeycode
    );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting right.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        enable,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic        feedback;

    // Taps 16,14,13,11 map to bits 0,2,3,5 of the right-shifting register.
    assign feedback = state_q[0] ^ state_q[2] ^ state_q[3] ^ state_q[5];

    // Advance once per frame while enabled.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= SEED;
        end else if (enable) begin
            state_q <= {feedback, state_q[15:1]};
        end
    end

    assign state = state_q;

endmodule

// File: rtl/ghost_dir_gen.sv
// Per-frame ghost direction generator: chase or random wander with wall avoidance.
module ghost_dir_gen
    import pacman_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = 32,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic             frame_clk,
    input logic             Reset,
    ghost_dir_gen_if.slave  bus
);

    localparam logic [7:0] HOLD_BASE = 8'(HOLD_FRAMES);

    state_e      state_q, state_d;
    logic [7:0]  code_q, code_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] lfsr;
    logic        lfsr_en;
    logic        unused_lfsr;

    assign lfsr_en     = !bus.pause;
    assign unused_lfsr = ^lfsr[15:6];

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .enable    (lfsr_en),
        .state     (lfsr)
    );

    // Bit index equals dir_e value: 0 up, 1 left, 2 down, 3 right.
    logic [3:0] open_mask, rev_mask, excl_mask, cand;
    logic       any_open;
    dir_e       cur_dir;
    logic       cur_valid;
    logic       cur_blocked;

    assign open_mask = {bus.mapR == 5'd0, bus.mapB == 5'd0, bus.mapL == 5'd0, bus.mapT == 5'd0};
    assign any_open  = |open_mask;

    // Decode the held key code back into a direction; NONE has no reverse.
    always_comb begin
        cur_valid = 1'b1;
        cur_dir   = DirUp;
        unique case (code_q)
            DIR_UP:    cur_dir = DirUp;
            DIR_LEFT:  cur_dir = DirLeft;
            DIR_DOWN:  cur_dir = DirDown;
            DIR_RIGHT: cur_dir = DirRight;
            default:   cur_valid = 1'b0;
        endcase
    end

    assign rev_mask    = cur_valid ? (4'b0001 << reverse_dir(cur_dir)) : 4'b0000;
    assign excl_mask   = open_mask & ~rev_mask;
    // Turning back is allowed only when it is the sole way out.
    assign cand        = (excl_mask != 4'b0000) ? excl_mask : open_mask;
    assign cur_blocked = cur_valid && !open_mask[cur_dir];

    // Chase: prefer the axis with the larger distance, ties go to Y.
    logic signed [10:0] dx, dy;
    logic [10:0]        adx, ady;
    dir_e               x_dir, y_dir, pri_dir, sec_dir, chase_dir;
    logic               pri_ok, sec_ok, chase_hit, chase_mode;

    assign dx         = $signed({1'b0, bus.targetX}) - $signed({1'b0, bus.ghostX});
    assign dy         = $signed({1'b0, bus.targetY}) - $signed({1'b0, bus.ghostY});
    assign adx        = dx[10] ? -dx : dx;
    assign ady        = dy[10] ? -dy : dy;
    assign x_dir      = dx[10] ? DirLeft : DirRight;
    assign y_dir      = dy[10] ? DirUp : DirDown;
    assign chase_mode = bus.chase_en && (lfsr[5:4] != 2'b00);

    // Pick the chase direction among candidates, or report a miss.
    always_comb begin
        if (adx > ady) begin
            pri_dir = x_dir;
            pri_ok  = (dx != 11'sd0);
            sec_dir = y_dir;
            sec_ok  = (dy != 11'sd0);
        end else begin
            pri_dir = y_dir;
            pri_ok  = (dy != 11'sd0);
            sec_dir = x_dir;
            sec_ok  = (dx != 11'sd0);
        end
        chase_hit = 1'b1;
        chase_dir = pri_dir;
        if (pri_ok && cand[pri_dir]) begin
            chase_dir = pri_dir;
        end else if (sec_ok && cand[sec_dir]) begin
            chase_dir = sec_dir;
        end else begin
            chase_hit = 1'b0;
        end
    end

    // First set bit of mask at or after start, wrapping modulo 4.
    function automatic dir_e scan_from(input logic [3:0] mask, input logic [1:0] start);
        dir_e       pick;
        logic [1:0] idx;
        pick = dir_e'(start);
        // Walk downward so the nearest hit is the one that survives.
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (mask[idx]) begin
                pick = dir_e'(idx);
            end
        end
        return pick;
    endfunction

    dir_e rnd_dir, pick_dir;
    assign rnd_dir  = scan_from(cand, lfsr[1:0]);
    assign pick_dir = (chase_mode && chase_hit) ? chase_dir : rnd_dir;

    // Next-state, next code and hold counter.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        if (bus.pause) begin
            state_d = StIdle;
            code_d  = DIR_NONE;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StDecide;
                end
                StDecide: begin
                    state_d = StHold;
                    if (any_open) begin
                        code_d = dir_code(pick_dir);
                        cnt_d  = HOLD_BASE + {4'b0000, lfsr[3:0]};
                    end else begin
                        // Boxed in: keep facing the same way and retry next frame.
                        cnt_d = 8'd1;
                    end
                end
                StHold: begin
                    cnt_d = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
                    if (cnt_q <= 8'd1 || cur_blocked) begin
                        state_d = StDecide;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State, code and counter registers.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            code_q  <= DIR_NONE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.randomkeycode = code_q;

endmodule

// File: doc/ghost_dir_gen.md
GHOST_DIR_GEN -- requirements
Module: ghost_dir_gen

Interface
REQ-001 Parameter HOLD_FRAMES, default 32: base number of frames a chosen direction is held.
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-003 frame_clk  input  1  clock; one rising edge per video frame.
REQ-004 Reset  input  1  reset Reset, asynchronous, active-high; clock frame_clk.
REQ-005 pause  input  1  game paused; direction generation frozen.
REQ-006 chase_en  input  1  1 = chase target, 0 = pure random wander.
REQ-007 mapL, mapR, mapB, mapT  input  5 each  wall probe beside ghost; 0 = open, nonzero = blocked.
REQ-008 ghostX, ghostY  input  10 each  current ghost centre, pixels.
REQ-009 targetX, targetY  input  10 each  chase target (Pac-Man centre), pixels.
REQ-010 randomkeycode  output  8  registered direction command: 8'h1A up, 8'h04 left, 8'h16 down, 8'h07 right, 8'h00 none.

Function
REQ-011 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance once per frame_clk edge unless pause=1.
REQ-012 FSM states: IDLE, DECIDE, HOLD.
REQ-013 IDLE: randomkeycode = 8'h00; next frame -> DECIDE when pause=0.
REQ-014 DECIDE lasts exactly one frame; the chosen code is registered at that edge and visible the following frame; FSM -> HOLD.
REQ-015 HOLD: code held; 8-bit hold counter decrements per frame; -> DECIDE when counter reaches 0 or the map probe for the current direction becomes nonzero (blocked).
REQ-016 On entering HOLD the counter SHALL load HOLD_FRAMES + lfsr[3:0] (8-bit add, HOLD_FRAMES+15 must be <= 255).
REQ-017 Candidate set: directions whose probe is 0, excluding the reverse of the current code; the reverse is used only if it is the sole open direction.
REQ-018 Chase mode is used when chase_en=1 and lfsr[5:4] != 2'b00; otherwise random mode.
REQ-019 Chase: dx = targetX - ghostX, dy = targetY - ghostY as 11-bit signed; primary axis is the larger |d| (tie -> Y); pick the primary-axis direction toward target if a candidate, else the secondary-axis direction if nonzero distance and a candidate, else fall through to random.
REQ-020 Random: start at index lfsr[1:0] in order UP(0), LEFT(1), DOWN(2), RIGHT(3); take the first candidate scanning upward modulo 4.
REQ-021 No candidate (all four blocked): keep the current code, load counter with 1, re-decide after one HOLD frame.
REQ-022 From IDLE (current code 8'h00) there is no reverse exclusion.
REQ-023 pause=1 in any state: FSM -> IDLE, randomkeycode -> 8'h00, counter cleared, LFSR frozen.
REQ-024 Output changes only on frame_clk edges; no combinational path from inputs to randomkeycode.

Reset
REQ-025 Reset asserted: state IDLE, randomkeycode 8'h00, hold counter 0, LFSR = LFSR_SEED, immediately and independent of frame_clk.
REQ-026 Reset deasserted mid-HOLD or mid-DECIDE: no partial decision survives; first DECIDE occurs on the second frame edge after release.

Structure
REQ-027 Shared package pacman_pkg SHALL hold the direction code constants (DIR_UP/LEFT/DOWN/RIGHT/NONE), the direction enum, and the reverse-direction function.
REQ-028 The LFSR SHALL be a separate sub-module lfsr16 (enable, seed parameter, 16-bit state out).
REQ-029 Candidate masking, chase selection and random scan are combinational inside ghost_dir_gen; only state, counter, code and LFSR are registered.

Verification
REQ-030 Reset, release, all maps 0, chase_en=0, LFSR_SEED -> frame 1 IDLE/8'h00, frame 2 code per seed lfsr[1:0], held for HOLD_FRAMES+lfsr[3:0] frames.
REQ-031 Code 8'h04 held, mapL goes nonzero, mapT=0, others blocked -> next frame DECIDE, following frame 8'h1A.
REQ-032 chase_en=1, lfsr[5:4]=01, ghost (142,166), target (300,170), all open -> 8'h07; set mapR blocked -> 8'h16.
REQ-033 Current 8'h07, only mapL open -> reverse chosen, 8'h04; all four blocked -> code stays 8'h07, re-decide every 2 frames.
REQ-034 pause=1 during HOLD for 10 frames -> 8'h00 next frame, LFSR value unchanged over the pause; pause=0 -> IDLE then DECIDE.
REQ-035 Reset pulsed between frame edges mid-HOLD -> output 8'h00 and LFSR = 16'hACE1 without waiting for a clock edge.
